cache_controller: RTL
=====================

// Module: cache_controller
// PURPOSE
//  2-way set-associative read cache, write-through / no-write-allocate, between MEM stage and SRAM_Controller.
//  Serves read hits combinationally (zero wait). Fills a 2-word line on a read miss via two SRAM_Controller reads.
//  Forwards every store straight to SRAM_Controller. Freezes the pipeline through ready=0 while SRAM is busy.
// PARAMETERS
//  SETS    64  number of sets (index = addr[8:3]).
//  TAG_W   10  tag width (tag = addr[18:9]). Word offset within the line = addr[2]; addr[1:0] ignored.
// PORTS
//  clk         in   1   system clock
//  rst         in   1   reset; synchronous, active-high
//  rd_en       in   1   load request from MEM stage
//  wr_en       in   1   store request from MEM stage
//  addr        in   32  byte address
//  wdata       in   32  store data
//  rdata       out  32  load data; valid when ready=1 and rd_en=1
//  ready       out  1   1 = request completes this cycle (pipeline may advance); 0 = freeze
//  sram_rd_en  out  1   read request to SRAM_Controller
//  sram_wr_en  out  1   write request to SRAM_Controller
//  sram_addr   out  32  byte address to SRAM_Controller
//  sram_wdata  out  32  store data to SRAM_Controller
//  sram_rdata  in   32  read data from SRAM_Controller
//  sram_ready  in   1   SRAM_Controller done (1 when idle; 1 on final wait cycle of an access)
// BEHAVIOUR
//  Reset
//   - state=IDLE. All valid bits and all LRU bits cleared.
//   - sram_rd_en=0, sram_wr_en=0. ready=1 while no request is pending.
//   - Reset mid-fill or mid-write: line is not written; the pending access is abandoned.
//  Request rules
//   - wr_en has priority if both enables are high.
//   - Requester holds addr/wdata/enables stable until ready=1. Request retires on the edge where ready=1.
//  Read hit: IDLE, rd_en, valid & tag match in a way.
//   - ready=1 same cycle; rdata = matching way's word[addr[2]].
//   - LRU updated at the edge.
//  LRU (1 bit per set)
//   - Access to way0 sets lru=1; access to way1 sets lru=0.
//   - Victim: way0 if invalid, else way1 if invalid, else way lru.
//  Read miss
//   - FILL_W0: sram_rd_en=1, sram_addr={addr[31:3],3'b000}. On sram_ready, latch sram_rdata into an even-word register; go to FILL_W1.
//   - FILL_W1: sram_rd_en=1, sram_addr={addr[31:3],3'b100}. On sram_ready:
//     - write {odd=sram_rdata, even=reg}, tag and valid=1 into the victim way;
//     - update LRU; ready=1 in that cycle;
//     - rdata = addr[2] ? sram_rdata : even reg; go to IDLE.
//   - ready=0 in all other fill cycles.
//  Write (hit or miss)
//   - IDLE+wr_en -> WRITE. sram_wr_en=1, sram_addr=addr, sram_wdata=wdata.
//   - On sram_ready: ready=1, go to IDLE.
//   - Hit: the matching way's word[addr[2]] is updated with wdata at that edge, and LRU updated.
//   - Miss: no allocation, cache unchanged.
//  Other rules
//   - sram_rd_en and sram_wr_en are never high together. Both are 0 in IDLE.
//   - Write hit to a line while it is resident keeps cache and SRAM coherent. No dirty state exists.
//   - States: IDLE, FILL_W0, FILL_W1, WRITE (2-bit encoding).
// STRUCTURE
//  - Shared defines header (defines.v): `CACHE_SETS, `CACHE_TAG_W, `CACHE_IDX_W, and the state encodings.
//  - Sub-module cache_array: tag/valid/data arrays for both ways plus the LRU bits.
//    - Combinational hit/way/word lookup.
//    - Synchronous write port (line fill, word update, LRU update, clear on rst).
//  - The top level holds the FSM, the even-word register and the output muxes.
// TESTING (SRAM model preloaded with mem[0x100]=0xA, mem[0x101]=0xB)
//  1. Idle, no enables -> ready=1, sram_rd_en=sram_wr_en=0, for 10 cycles after reset.
//  2. Read 0x400 -> sram reads at 0x400 then 0x404, ready=1 with rdata=0xA.
//     Then read 0x404 -> ready=1 same cycle, rdata=0xB, no sram_rd_en.
//  3. Write 0x400 wdata=0x32 (hit) -> sram_wr_en with sram_wdata=0x32 until sram_ready.
//     Then read 0x400 -> hit, rdata=0x32.
//  4. Write 0x800 (miss) -> SRAM mem[0x200]=data. Then read 0x800 -> miss fill (no allocation on the write).
//  5. LRU, index 0: read 0x000 then 0x200 (both fill); read 0x000 (hit); read 0x400 (evicts 0x200 line).
//     Then read 0x000 -> hit; read 0x200 -> miss.
//  6. rst=1 during FILL_W1 -> next cycle IDLE, sram_rd_en=0. Re-read of the same line misses (valid cleared).

Source files
------------

// File: rtl/cache_controller_pkg.sv
// Shared sizing, FSM state encoding and victim selection for the 2-way read cache.
package cache_controller_pkg;

  localparam int CACHE_SETS  = 64;
  localparam int CACHE_TAG_W = 10;
  localparam int CACHE_IDX_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FILL_W0 = 2'b01,
    ST_FILL_W1 = 2'b10,
    ST_WRITE   = 2'b11
  } state_t;

  // Empty ways are filled first (way0 before way1); otherwise the LRU way is evicted.
  function automatic logic pick_victim(input logic v0, input logic v1, input logic lru);
    if (!v0) begin
      return 1'b0;
    end else if (!v1) begin
      return 1'b1;
    end else begin
      return lru;
    end
  endfunction

endpackage

// File: rtl/cache_controller_cache_array.sv
// Tag/valid/data storage for both ways plus per-set LRU bit.
// Lookup is combinational; fills, word updates and LRU updates happen at the clock edge.
module cache_array
  import cache_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CACHE_IDX_W-1:0] idx,
  input  logic [CACHE_TAG_W-1:0] tag,
  input  logic                   off,
  output logic                   hit,
  output logic                   hit_way,
  output logic [31:0]            hit_word,
  output logic                   victim,
  input  logic                   fill_en,
  input  logic [31:0]            fill_even,
  input  logic [31:0]            fill_odd,
  input  logic                   word_en,
  input  logic [31:0]            word_data,
  input  logic                   lru_en,
  input  logic                   lru_way
);

  logic [CACHE_TAG_W-1:0] tag_mem  [2][CACHE_SETS];
  logic [31:0]            data_mem [2][CACHE_SETS][2];
  logic [CACHE_SETS-1:0]  valid0;
  logic [CACHE_SETS-1:0]  valid1;
  logic [CACHE_SETS-1:0]  lru_bits;
  logic                   hit0;
  logic                   hit1;

  assign hit0 = valid0[idx] && (tag_mem[0][idx] == tag);
  assign hit1 = valid1[idx] && (tag_mem[1][idx] == tag);

  always_comb begin
    hit      = hit0 | hit1;
    hit_way  = hit1;
    hit_word = data_mem[hit1][idx][off];
    victim   = pick_victim(valid0[idx], valid1[idx], lru_bits[idx]);
  end

  // lru bit names the way to evict next, so it points away from the way just used
  always_ff @(posedge clk) begin
    if (rst) begin
      valid0   <= '0;
      valid1   <= '0;
      lru_bits <= '0;
    end else begin
      if (fill_en) begin
        if (victim) begin
          valid1[idx] <= 1'b1;
        end else begin
          valid0[idx] <= 1'b1;
        end
      end
      if (lru_en) begin
        lru_bits[idx] <= ~lru_way;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_en) begin
        tag_mem[victim][idx]     <= tag;
        data_mem[victim][idx][0] <= fill_even;
        data_mem[victim][idx][1] <= fill_odd;
      end else if (word_en) begin
        data_mem[hit_way][idx][off] <= word_data;
      end
    end
  end

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative write-through read cache between the MEM stage and the SRAM controller.
// Read hits complete with zero wait; misses fill a 2-word line; stores always go to SRAM.
module cache_controller
  import cache_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);

  state_t      state;
  logic [31:0] even_word;
  logic        hit;
  logic        hit_way;
  logic        victim;
  logic [31:0] hit_word;
  logic        fill_en;
  logic        word_en;
  logic        lru_en;
  logic        lru_way;

  cache_array u_array (
    .clk       (clk),
    .rst       (rst),
    .idx       (addr[8:3]),
    .tag       (addr[18:9]),
    .off       (addr[2]),
    .hit       (hit),
    .hit_way   (hit_way),
    .hit_word  (hit_word),
    .victim    (victim),
    .fill_en   (fill_en),
    .fill_even (even_word),
    .fill_odd  (sram_rdata),
    .word_en   (word_en),
    .word_data (wdata),
    .lru_en    (lru_en),
    .lru_way   (lru_way)
  );

  // Request sequencing; stores take priority over loads
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      even_word <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_en) begin
            state <= ST_WRITE;
          end else if (rd_en && !hit) begin
            state <= ST_FILL_W0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_FILL_W0: begin
          if (sram_ready) begin
            even_word <= sram_rdata;
            state     <= ST_FILL_W1;
          end
        end
        ST_FILL_W1: begin
          if (sram_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (sram_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake, SRAM request and cache update decode; hit path stays combinational for zero-wait loads
  always_comb begin
    ready      = 1'b0;
    rdata      = hit_word;
    sram_rd_en = 1'b0;
    sram_wr_en = 1'b0;
    sram_addr  = 32'd0;
    sram_wdata = 32'd0;
    fill_en    = 1'b0;
    word_en    = 1'b0;
    lru_en     = 1'b0;
    lru_way    = hit_way;
    case (state)
      ST_IDLE: begin
        if (wr_en) begin
          ready = 1'b0;
        end else if (rd_en) begin
          ready  = hit;
          lru_en = hit;
        end else begin
          ready = 1'b1;
        end
      end
      ST_FILL_W0: begin
        sram_rd_en = 1'b1;
        sram_addr  = {addr[31:3], 3'b000};
      end
      ST_FILL_W1: begin
        sram_rd_en = 1'b1;
        sram_addr  = {addr[31:3], 3'b100};
        rdata      = addr[2] ? sram_rdata : even_word;
        lru_way    = victim;
        if (sram_ready) begin
          ready   = 1'b1;
          fill_en = 1'b1;
          lru_en  = 1'b1;
        end else begin
          ready = 1'b0;
        end
      end
      ST_WRITE: begin
        sram_wr_en = 1'b1;
        sram_addr  = addr;
        sram_wdata = wdata;
        if (sram_ready) begin
          ready   = 1'b1;
          word_en = hit;
          lru_en  = hit;
        end else begin
          ready = 1'b0;
        end
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

endmodule
